axi_lite_requester: RTL and testbench
=====================================

# axi_lite_requester

AXI4-Lite initiator that turns a simple single-outstanding memory request port (req/gnt, rvalid) into single-beat AXI transactions on an `axi_req_t`/`axi_resp_t` bus. It is the master-side counterpart of the team's AXI-lite slave adapter. It lets small control engines such as DMA descriptor fetchers and debug bridges drive CLINT/PLIC-style register slaves over the Ariane AXI fabric. Exactly one transaction is in flight at a time.

## Interface
- AXI_ADDR_WIDTH, 64, address width of the request port and AW/AR
- AXI_DATA_WIDTH, 64, data width; power of two, ≥ 8
- AXI_ID_WIDTH, 10, width of aw_id/ar_id
- AXI_ID, 0, constant ID driven on aw_id/ar_id
- axi_req_t, ariane_axi::req_t, AXI request struct type
- axi_resp_t, ariane_axi::resp_t, AXI response struct type
- clk_i  in  1  clock; all logic on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- be_i  in  AXI_DATA_WIDTH/8  write byte enables
- wdata_i  in  AXI_DATA_WIDTH  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle completion pulse for reads and writes
- rdata_o  out  AXI_DATA_WIDTH  read data; valid while rvalid_o is high
- err_o  out  1  response was SLVERR/DECERR; valid while rvalid_o is high
- axi_req_o  out  axi_req_t  AXI request channels
- axi_resp_i  in  axi_resp_t  AXI response channels

## Operation
- FSM states: IDLE, WR (AW and W outstanding), WR_B, RD_AR, RD_R.
- IDLE:
  - gnt_o = req_i, combinationally.
  - On req_i, latch addr, we, be and wdata.
  - Go to WR if we_i, else RD_AR.
- WR:
  - aw_valid and w_valid are raised together. Each drops independently after its own handshake; aw_done_q and w_done_q track this.
  - Go to WR_B in the cycle where both are done, including the same-cycle handshake of the last one.
  - Either channel may complete first, and both may complete in the same cycle.
- WR_B:
  - b_ready = 1.
  - On b_valid, capture err = b_resp[1] and go to IDLE.
- RD_AR:
  - ar_valid = 1 until ar_ready, then go to RD_R.
- RD_R:
  - r_ready = 1.
  - On r_valid, capture r_data and err = r_resp[1], then go to IDLE.
- Completion outputs:
  - rvalid_o, rdata_o and err_o are registered and pulse exactly one cycle after the B or R handshake.
  - rdata_o holds its last value otherwise.
  - rdata_o is unchanged by writes.
- Fixed AXI fields:
  - aw/ar: len = 0, size = log2(AXI_DATA_WIDTH/8), burst = INCR, id = AXI_ID.
  - lock, cache, prot, qos, region and user are all 0.
  - w_last = 1, w_strb = latched be.
- Responses:
  - b_id and r_id are ignored.
  - r_last is ignored (single beat).
  - EXOKAY is treated as OK.
- Every valid signal, once raised, holds with stable payload until its handshake (AXI rule).
- Payloads are driven from the latched registers only, never from the request port.
- No new gnt_o is issued while in any non-IDLE state, so there is only one outstanding transaction.
- gnt_o may be issued in the same cycle that rvalid_o pulses.

## Timing
- Reset values:
  - state IDLE; all AXI valids and readies 0.
  - gnt_o follows req_i in IDLE.
  - rvalid_o 0, err_o 0, rdata_o 0; latched fields 0.
- Read, zero-wait slave:
  - gnt at cycle 0.
  - ar_valid cycles 1..k.
  - r_ready from the cycle after the AR handshake.
  - rvalid_o one cycle after the R handshake.
  - Minimum gnt→rvalid_o is 3 cycles.
- Write, zero-wait slave:
  - gnt at cycle 0.
  - aw_valid and w_valid in cycle 1.
  - b_ready from cycle 2.
  - rvalid_o one cycle after the B handshake.
  - Minimum is 3 cycles.
- A B or R valid seen outside WR_B/RD_R is ignored (no ready is asserted).
- Reset mid-transaction drops all valids immediately (asynchronous). The in-flight transaction is abandoned and no rvalid_o is produced.

## Test plan
- Read, zero-wait slave returning 0xDEAD_BEEF_0123_4567 OKAY at 0x0200_BFF8:
  - ar_addr = 0x0200_BFF8, ar_len = 0, ar_size = 3.
  - rvalid_o at cycle 3 with that data, err_o = 0.
- Write of 0x1, be = 0x0F, to 0x0200_4000:
  - Slave asserts aw_ready 3 cycles before w_ready.
  - aw_valid drops after its handshake while w_valid holds stable.
  - b_ready only after both handshakes.
  - A single rvalid_o pulse.
- Same-cycle AW+W handshake, then b_resp = SLVERR:
  - rvalid_o with err_o = 1.
  - rdata_o unchanged from the previous read.
- Back-to-back requests with req_i held high:
  - Second gnt_o only in IDLE.
  - Payload registers never change while a valid is pending; checked by an AXI handshake-stability assertion.
- Read with the slave stalling ar_ready 5 cycles and r_valid 4 cycles, DECERR returned:
  - ar_addr stable throughout.
  - err_o = 1, no extra pulses.
- rst_ni pulled low while in WR_B:
  - All valids, readies and rvalid_o go to 0 asynchronously.
  - After release, a fresh read completes normally.

Source files
------------

// File: rtl/axi_lite_requester.sv
// Single-outstanding AXI4-Lite initiator: converts a req/gnt/rvalid memory port into
// single-beat AXI read/write transactions. Includes the ariane_axi bus type package.

package ariane_axi;
  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ID_WIDTH   = 10;
  localparam int unsigned USER_WIDTH = 1;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [USER_WIDTH-1:0] user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_lite_requester #(
  parameter int unsigned                AXI_ADDR_WIDTH = 64,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                AXI_ID_WIDTH   = 10,
  parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = '0,
  parameter type                        axi_req_t      = ariane_axi::req_t,
  parameter type                        axi_resp_t     = ariane_axi::resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output axi_req_t                    axi_req_o,
  input  axi_resp_t                   axi_resp_i
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  AXI_SIZE   = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  state_t                    state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [STRB_WIDTH-1:0]     be_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      aw_valid_q, w_valid_q, ar_valid_q;
  logic                      b_ready_q, r_ready_q;
  logic                      aw_done_q, w_done_q;
  logic                      rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic aw_fire, w_fire;
  assign aw_fire = aw_valid_q & axi_resp_i.aw_ready;
  assign w_fire  = w_valid_q  & axi_resp_i.w_ready;

  // Only IDLE may accept, which is what keeps a single transaction in flight.
  assign gnt_o = req_i && (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
            if (we_i) begin
              state_q    <= WR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
            end else begin
              state_q    <= RD_AR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (aw_fire) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_fire) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          // Counts a handshake landing this very cycle as done.
          if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
            state_q   <= WR_B;
            b_ready_q <= 1'b1;
          end
        end
        WR_B: begin
          if (axi_resp_i.b_valid) begin
            b_ready_q <= 1'b0;
            err_q     <= axi_resp_i.b.resp[1];
            rvalid_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        RD_AR: begin
          if (axi_resp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RD_R;
          end
        end
        RD_R: begin
          if (axi_resp_i.r_valid) begin
            r_ready_q <= 1'b0;
            rdata_q   <= axi_resp_i.r.data;
            err_q     <= axi_resp_i.r.resp[1];
            rvalid_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // NOTE: the struct gets a full default first so no field can infer a latch.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AXI_SIZE;
    axi_req_o.aw.burst = ariane_axi::BURST_INCR;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.id    = AXI_ID;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AXI_SIZE;
    axi_req_o.ar.burst = ariane_axi::BURST_INCR;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  // IDs, r_last, user and the low response bit carry no meaning for a single-beat,
  // single-ID initiator; EXOKAY folds into OK through resp[1].
  logic unused_resp;
  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                         axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.resp[0],
                         axi_resp_i.r.last};

endmodule

// File: tb/tb_axi_lite_requester.sv
// Directed bench for axi_lite_requester: the slave side is driven step by step and every
// expectation is a hand-computed constant; payload stability is checked each cycle.

module tb_axi_lite_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [63:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        gnt, rvalid, err;
  logic [63:0] rdata;
  ariane_axi::req_t  axi_req;
  ariane_axi::resp_t resp;

  int total = 0;
  int bad   = 0;

  logic                 pend_aw, pend_w, pend_ar;
  ariane_axi::ax_chan_t prev_aw, prev_ar;
  ariane_axi::w_chan_t  prev_w;

  always #5 clk = ~clk;

  axi_lite_requester dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .be_i       (be),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err),
    .axi_req_o  (axi_req),
    .axi_resp_i (resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: snapshot pending valids after this cycle's drive, then check
  // at the next mid-cycle that any unaccepted valid held with an unchanged payload.
  task automatic step();
    #1;
    pend_aw = rst_n && axi_req.aw_valid && !resp.aw_ready;
    pend_w  = rst_n && axi_req.w_valid  && !resp.w_ready;
    pend_ar = rst_n && axi_req.ar_valid && !resp.ar_ready;
    prev_aw = axi_req.aw;
    prev_w  = axi_req.w;
    prev_ar = axi_req.ar;
    @(posedge clk);
    @(negedge clk);
    if (pend_aw) chk("aw_hold", 64'(axi_req.aw_valid && (axi_req.aw == prev_aw)), 64'd1);
    if (pend_w)  chk("w_hold",  64'(axi_req.w_valid  && (axi_req.w  == prev_w)),  64'd1);
    if (pend_ar) chk("ar_hold", 64'(axi_req.ar_valid && (axi_req.ar == prev_ar)), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = '0;
    wdata = '0;
    resp  = '0;

    // Reset state
    @(negedge clk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'd0);
    chk("rst_readies", 64'({axi_req.b_ready, axi_req.r_ready}), 64'd0);
    chk("rst_gnt_lo", 64'(gnt), 64'd0);
    req = 1'b1;
    #1 chk("rst_gnt_hi", 64'(gnt), 64'd1);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero-wait read of 0x0200_BFF8
    req = 1'b1; we = 1'b0; addr = 64'h0200_BFF8;
    resp.ar_ready = 1'b1;
    #1 chk("rd_gnt", 64'(gnt), 64'd1);
    step();
    req = 1'b0;
    chk("rd_ar_valid", 64'(axi_req.ar_valid), 64'd1);
    chk("rd_ar_addr", axi_req.ar.addr, 64'h0200_BFF8);
    chk("rd_ar_len", 64'(axi_req.ar.len), 64'd0);
    chk("rd_ar_size", 64'(axi_req.ar.size), 64'd3);
    chk("rd_ar_burst", 64'(axi_req.ar.burst), 64'd1);
    chk("rd_r_ready_c1", 64'(axi_req.r_ready), 64'd0);
    step();
    chk("rd_ar_drop", 64'(axi_req.ar_valid), 64'd0);
    chk("rd_r_ready_c2", 64'(axi_req.r_ready), 64'd1);
    resp.ar_ready = 1'b0;
    resp.r_valid  = 1'b1;
    resp.r.data   = 64'hDEAD_BEEF_0123_4567;
    resp.r.resp   = 2'b00;
    step();
    chk("rd_rvalid_c3", 64'(rvalid), 64'd1);
    chk("rd_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    chk("rd_err", 64'(err), 64'd0);
    chk("rd_r_ready_c3", 64'(axi_req.r_ready), 64'd0);
    resp = '0;
    step();
    chk("rd_rvalid_c4", 64'(rvalid), 64'd0);

    // Write 0x1, be 0x0F, AW accepted three cycles before W
    req = 1'b1; we = 1'b1; addr = 64'h0200_4000; be = 8'h0F; wdata = 64'h1;
    #1 chk("wr_gnt", 64'(gnt), 64'd1);
    step();
    req = 1'b0;
    chk("wr_aw_w_valid", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b11);
    chk("wr_aw_addr", axi_req.aw.addr, 64'h0200_4000);
    chk("wr_aw_size", 64'(axi_req.aw.size), 64'd3);
    chk("wr_aw_len_id", 64'({axi_req.aw.len, axi_req.aw.id}), 64'd0);
    chk("wr_w_data", axi_req.w.data, 64'h1);
    chk("wr_w_strb", 64'(axi_req.w.strb), 64'h0F);
    chk("wr_w_last", 64'(axi_req.w.last), 64'd1);
    resp.aw_ready = 1'b1;
    step();
    resp.aw_ready = 1'b0;
    chk("wr_aw_drop", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b01);
    chk("wr_b_ready_early", 64'(axi_req.b_ready), 64'd0);
    step();
    step();
    chk("wr_w_still", 64'({axi_req.w_valid, axi_req.b_ready}), 64'b10);
    resp.w_ready = 1'b1;
    step();
    resp.w_ready = 1'b0;
    chk("wr_w_drop", 64'(axi_req.w_valid), 64'd0);
    chk("wr_b_ready", 64'(axi_req.b_ready), 64'd1);
    chk("wr_no_early_rvalid", 64'(rvalid), 64'd0);
    resp.b_valid = 1'b1;
    resp.b.resp  = 2'b00;
    step();
    resp = '0;
    chk("wr_rvalid", 64'(rvalid), 64'd1);
    chk("wr_err", 64'(err), 64'd0);
    chk("wr_rdata_kept", rdata, 64'hDEAD_BEEF_0123_4567);
    chk("wr_b_ready_drop", 64'(axi_req.b_ready), 64'd0);
    step();
    chk("wr_single_pulse", 64'(rvalid), 64'd0);

    // Same-cycle AW+W handshake, SLVERR response
    req = 1'b1; we = 1'b1; addr = 64'h0200_0008; be = 8'hFF; wdata = 64'hAA;
    resp.aw_ready = 1'b1;
    resp.w_ready  = 1'b1;
    step();
    req = 1'b0;
    chk("sc_valids", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b11);
    step();
    resp.aw_ready = 1'b0;
    resp.w_ready  = 1'b0;
    chk("sc_valids_drop", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b00);
    chk("sc_b_ready", 64'(axi_req.b_ready), 64'd1);
    resp.b_valid = 1'b1;
    resp.b.resp  = 2'b10;
    step();
    resp = '0;
    chk("sc_rvalid", 64'(rvalid), 64'd1);
    chk("sc_err", 64'(err), 64'd1);
    chk("sc_rdata_kept", rdata, 64'hDEAD_BEEF_0123_4567);
    step();
    chk("sc_rvalid_drop", 64'(rvalid), 64'd0);

    // Back-to-back: req held high, slave always ready/valid
    resp.ar_ready = 1'b1;
    resp.aw_ready = 1'b1;
    resp.w_ready  = 1'b1;
    resp.r_valid  = 1'b1;
    resp.r.data   = 64'h1111_2222_3333_4444;
    resp.b_valid  = 1'b1;
    req = 1'b1; we = 1'b0; addr = 64'h0200_0100;
    #1 chk("bb_gnt_c0", 64'(gnt), 64'd1);
    step();
    chk("bb_gnt_c1", 64'(gnt), 64'd0);
    chk("bb_ar_c1", 64'({axi_req.ar_valid, axi_req.b_ready}), 64'b10);
    step();
    chk("bb_gnt_c2", 64'(gnt), 64'd0);
    chk("bb_r_ready_c2", 64'(axi_req.r_ready), 64'd1);
    step();
    chk("bb_rvalid_c3", 64'(rvalid), 64'd1);
    chk("bb_rdata_c3", rdata, 64'h1111_2222_3333_4444);
    chk("bb_gnt_c3", 64'(gnt), 64'd1);
    we = 1'b1; addr = 64'h0200_0200; be = 8'hF0; wdata = 64'h2222;
    step();
    chk("bb_gnt_c4", 64'(gnt), 64'd0);
    chk("bb_aw_w_c4", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready}), 64'b110);
    chk("bb_aw_addr", axi_req.aw.addr, 64'h0200_0200);
    chk("bb_w_strb", 64'(axi_req.w.strb), 64'hF0);
    step();
    chk("bb_gnt_c5", 64'(gnt), 64'd0);
    chk("bb_b_r_ready_c5", 64'({axi_req.b_ready, axi_req.r_ready}), 64'b10);
    step();
    chk("bb_rvalid_c6", 64'(rvalid), 64'd1);
    chk("bb_err_c6", 64'(err), 64'd0);
    chk("bb_rdata_c6", rdata, 64'h1111_2222_3333_4444);
    chk("bb_gnt_c6", 64'(gnt), 64'd1);
    req  = 1'b0;
    resp = '0;
    step();
    chk("bb_idle_c7", 64'({gnt, rvalid, axi_req.aw_valid, axi_req.ar_valid}), 64'd0);

    // Stalled read: ar_ready after 5 cycles, r_valid after 4, DECERR
    req = 1'b1; we = 1'b0; addr = 64'h0C00_0004;
    step();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("st_ar_valid", 64'(axi_req.ar_valid), 64'd1);
      chk("st_ar_addr", axi_req.ar.addr, 64'h0C00_0004);
      if (i == 5) resp.ar_ready = 1'b1;
      step();
    end
    resp.ar_ready = 1'b0;
    chk("st_ar_drop", 64'(axi_req.ar_valid), 64'd0);
    for (int j = 0; j < 5; j++) begin
      chk("st_r_ready", 64'(axi_req.r_ready), 64'd1);
      chk("st_no_rvalid", 64'(rvalid), 64'd0);
      if (j == 4) begin
        resp.r_valid = 1'b1;
        resp.r.data  = 64'hBAD0_0000_0000_0BAD;
        resp.r.resp  = 2'b11;
      end
      step();
    end
    resp = '0;
    chk("st_rvalid", 64'(rvalid), 64'd1);
    chk("st_err", 64'(err), 64'd1);
    chk("st_rdata", rdata, 64'hBAD0_0000_0000_0BAD);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_no_extra", 64'({rvalid, axi_req.r_ready}), 64'd0);
    end

    // Asynchronous reset while waiting in WR_B
    req = 1'b1; we = 1'b1; addr = 64'h0200_0010; be = 8'hFF; wdata = 64'h77;
    resp.aw_ready = 1'b1;
    resp.w_ready  = 1'b1;
    step();
    req = 1'b0;
    step();
    resp = '0;
    chk("ar_wr_b_ready", 64'(axi_req.b_ready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'd0);
    chk("ar_readies", 64'({axi_req.b_ready, axi_req.r_ready}), 64'd0);
    chk("ar_rvalid", 64'(rvalid), 64'd0);
    chk("ar_rdata", rdata, 64'd0);
    resp.b_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_no_completion", 64'({rvalid, axi_req.b_ready}), 64'd0);
    resp = '0;
    step();
    chk("ar_still_idle", 64'(rvalid), 64'd0);

    // Fresh read after reset
    req = 1'b1; we = 1'b0; addr = 64'h0200_BFF8;
    resp.ar_ready = 1'b1;
    #1 chk("fr_gnt", 64'(gnt), 64'd1);
    step();
    req = 1'b0;
    chk("fr_ar_addr", axi_req.ar.addr, 64'h0200_BFF8);
    step();
    resp.ar_ready = 1'b0;
    resp.r_valid  = 1'b1;
    resp.r.data   = 64'h55;
    step();
    resp = '0;
    chk("fr_rvalid", 64'(rvalid), 64'd1);
    chk("fr_rdata", rdata, 64'h55);
    chk("fr_err", 64'(err), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
